// File: rtl/cordic_pkg.sv
// cordic_pkg: shared width, FSM state type, arctangent table and Q-format constants
// Angles are unsigned with 2^22 = pi/4; vectors are signed Q1.23.
package cordic_pkg;
   localparam int W = 24;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
   localparam logic [W-1:0] ATAN_LUT [24] = '{
      24'd4194304, 24'd2476043, 24'd1308273, 24'd664100, 24'd333339, 24'd166832,
      24'd83436,   24'd41721,   24'd20861,   24'd10430,  24'd5215,   24'd2608,
      24'd1304,    24'd652,     24'd326,     24'd163,    24'd81,     24'd41,
      24'd20,      24'd10,      24'd5,       24'd3,      24'd1,      24'd1
   };
   localparam logic [W-1:0] PI_4  = 24'd4194304;
   localparam logic [W-1:0] K_Q23 = 24'd5094007;
endpackage

// File: rtl/cordic_iter_ctrl_stage.sv
// cordic_iter_ctrl_stage: single combinational CORDIC micro-rotation
// Inputs : x_init/y_init current vector, x_shift/y_shift pre-shifted operands,
//          angle accumulated angle, delta_angle arctangent step, target_angle,
//          select {force, iteration[2:0]}, valid (outputs pass through when low)
// Outputs: x_out/y_out rotated vector, angle_out updated angle
module cordic_iter_ctrl_stage import cordic_pkg::*; (
   input  logic signed [W-1:0] x_init,
   input  logic signed [W-1:0] y_init,
   input  logic signed [W-1:0] x_shift,
   input  logic signed [W-1:0] y_shift,
   input  logic        [W-1:0] angle,
   input  logic        [W-1:0] delta_angle,
   input  logic        [W-1:0] target_angle,
   input  logic        [3:0]   select,
   input  logic                valid,
   output logic signed [W-1:0] x_out,
   output logic signed [W-1:0] y_out,
   output logic        [W-1:0] angle_out
);
   logic dir;
   logic unused_sel;
   assign unused_sel = ^select[2:0];
   // Rotate positive while below target (unsigned compare) or when forced.
   assign dir       = select[3] | (angle < target_angle);
   assign x_out     = !valid ? x_init : dir ? x_init - y_shift : x_init + y_shift;
   assign y_out     = !valid ? y_init : dir ? y_init + x_shift : y_init - x_shift;
   assign angle_out = !valid ? angle  : dir ? angle + delta_angle : angle - delta_angle;
endmodule

// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl: iterative CORDIC rotation controller around one shared rotation stage
// Ports: clk, rst_n (async active-low); in_valid/in_ready with in_x, in_y (signed Q1.23),
//        in_target (2^22 = pi/4), in_force; out_valid/out_ready with out_x, out_y,
//        out_angle, out_iters.
// Option: define CORDIC_EARLY_EXIT_EN to finish as soon as the angle hits the target exactly.
module cordic_iter_ctrl import cordic_pkg::*; #(
   parameter int ITER = 16,
   parameter int W    = 24
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [W-1:0] in_x,
   input  logic signed [W-1:0] in_y,
   input  logic        [W-1:0] in_target,
   input  logic                in_force,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [W-1:0] out_x,
   output logic signed [W-1:0] out_y,
   output logic        [W-1:0] out_angle,
   output logic        [4:0]   out_iters
);
   state_e              state_q;
   logic signed [W-1:0] x_q, y_q, x_d, y_d;
   logic        [W-1:0] ang_q, ang_d, tgt_q;
   logic                frc_q, in_ready_q, out_valid_q, last;
   logic        [4:0]   it_q, iters_q;

   cordic_iter_ctrl_stage u_stage (
      .x_init      (x_q),
      .y_init      (y_q),
      .x_shift     (x_q >>> it_q),
      .y_shift     (y_q >>> it_q),
      .angle       (ang_q),
      .delta_angle (ATAN_LUT[it_q]),
      .target_angle(tgt_q),
      .select      ({frc_q, it_q[2:0]}),
      .valid       (state_q == RUN),
      .x_out       (x_d),
      .y_out       (y_d),
      .angle_out   (ang_d)
   );

`ifdef CORDIC_EARLY_EXIT_EN
   assign last = (it_q == 5'(ITER - 1)) || (!frc_q && ang_d == tgt_q);
`else
   assign last = it_q == 5'(ITER - 1);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         ang_q       <= '0;
         tgt_q       <= '0;
         frc_q       <= 1'b0;
         it_q        <= '0;
         iters_q     <= '0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               x_q        <= in_x;
               y_q        <= in_y;
               ang_q      <= '0;
               tgt_q      <= in_target;
               frc_q      <= in_force;
               it_q       <= '0;
               in_ready_q <= 1'b0;
               state_q    <= RUN;
            end
            RUN: begin
               x_q   <= x_d;
               y_q   <= y_d;
               ang_q <= ang_d;
               it_q  <= it_q + 5'd1;
               // it+1 equals ITER on the final commit, or the early-exit count.
               if (last) begin
                  iters_q     <= it_q + 5'd1;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: if (out_ready) begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_x     = x_q;
   assign out_y     = y_q;
   assign out_angle = ang_q;
   assign out_iters = iters_q;
endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// tb_cordic_iter_ctrl: randomized self-checking bench for cordic_iter_ctrl (ITER=16, 2 and 1)
module tb_cordic_iter_ctrl;
   localparam logic [23:0] LUT [24] = '{
      24'd4194304, 24'd2476043, 24'd1308273, 24'd664100, 24'd333339, 24'd166832,
      24'd83436,   24'd41721,   24'd20861,   24'd10430,  24'd5215,   24'd2608,
      24'd1304,    24'd652,     24'd326,     24'd163,    24'd81,     24'd41,
      24'd20,      24'd10,      24'd5,       24'd3,      24'd1,      24'd1
   };
   logic clk = 0, rst_n = 0;
   logic signed [23:0] dx = 0, dy = 0;
   logic [23:0] dt = 0;
   logic df = 0;
   logic iv16 = 0, or16 = 0, rdy16, ov16;
   logic iv2 = 0, or2 = 0, rdy2, ov2;
   logic iv1 = 0, or1 = 0, rdy1, ov1;
   logic signed [23:0] ox16, oy16, ox2, oy2, ox1, oy1;
   logic [23:0] oa16, oa2, oa1;
   logic [4:0] oi16, oi2, oi1;
   int n_cmp = 0, n_bad = 0, cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cordic_iter_ctrl #(.ITER(16)) dut16 (.clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(rdy16),
      .in_x(dx), .in_y(dy), .in_target(dt), .in_force(df), .out_valid(ov16), .out_ready(or16),
      .out_x(ox16), .out_y(oy16), .out_angle(oa16), .out_iters(oi16));
   cordic_iter_ctrl #(.ITER(2)) dut2 (.clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(rdy2),
      .in_x(dx), .in_y(dy), .in_target(dt), .in_force(df), .out_valid(ov2), .out_ready(or2),
      .out_x(ox2), .out_y(oy2), .out_angle(oa2), .out_iters(oi2));
   cordic_iter_ctrl #(.ITER(1)) dut1 (.clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1),
      .in_x(dx), .in_y(dy), .in_target(dt), .in_force(df), .out_valid(ov1), .out_ready(or1),
      .out_x(ox1), .out_y(oy1), .out_angle(oa1), .out_iters(oi1));

   // Reference: n micro-rotations computed directly from the rotation rules.
   function automatic void model(input logic signed [23:0] x0, input logic signed [23:0] y0,
                                 input logic [23:0] tgt, input logic frc, input int n,
                                 output logic [23:0] xo, output logic [23:0] yo,
                                 output logic [23:0] ao, output int cnt);
      logic signed [23:0] x, y, xs, ys;
      logic [23:0] a;
      x = x0; y = y0; a = 0; cnt = n;
      for (int k = 0; k < n; k++) begin
         xs = x >>> k; ys = y >>> k;
         if (frc || a < tgt) begin x = x - ys; y = y + xs; a = a + LUT[k]; end
         else begin x = x + ys; y = y - xs; a = a - LUT[k]; end
`ifdef CORDIC_EARLY_EXIT_EN
         if (!frc && a == tgt) begin cnt = k + 1; break; end
`endif
      end
      xo = x; yo = y; ao = a;
   endfunction

   task automatic job16(input logic [23:0] x, input logic [23:0] y, input logic [23:0] t,
                        input logic f, output int lat);
      @(negedge clk);
      dx = x; dy = y; dt = t; df = f; iv16 = 1;
      @(negedge clk);
      iv16 = 0; lat = 0;
      while (!ov16 && lat < 200) begin @(negedge clk); lat++; end
   endtask

   task automatic take16;
      or16 = 1; @(negedge clk); or16 = 0;
   endtask

   task automatic check16(input string nm, input logic [23:0] x, input logic [23:0] y,
                          input logic [23:0] t, input logic f, input int lat);
      logic [23:0] ex, ey, ea; int ec;
      model(x, y, t, f, 16, ex, ey, ea, ec);
      n_cmp++; if (lat !== ec) begin n_bad++; $display("FAIL %s_latency got %0d want %0d", nm, lat, ec); end
      n_cmp++; if (ox16 !== ex) begin n_bad++; $display("FAIL %s_x got %0d want %0d", nm, ox16, $signed(ex)); end
      n_cmp++; if (oy16 !== ey) begin n_bad++; $display("FAIL %s_y got %0d want %0d", nm, oy16, $signed(ey)); end
      n_cmp++; if (oa16 !== ea) begin n_bad++; $display("FAIL %s_angle got %0d want %0d", nm, oa16, ea); end
      n_cmp++; if (oi16 !== 5'(ec)) begin n_bad++; $display("FAIL %s_iters got %0d want %0d", nm, oi16, ec); end
   endtask

   task automatic test_reset;
      n_cmp++; if (rdy16 !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", rdy16); end
      n_cmp++; if (ov16 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", ov16); end
      n_cmp++; if ({ox16, oy16, oa16, oi16} !== 77'd0) begin n_bad++; $display("FAIL reset_outputs got x=%0d y=%0d a=%0d i=%0d want 0", ox16, oy16, oa16, oi16); end
      n_cmp++; if ({rdy2, ov2, rdy1, ov1} !== 4'b1010) begin n_bad++; $display("FAIL reset_small_duts got %b want 1010", {rdy2, ov2, rdy1, ov1}); end
   endtask

   task automatic test_known;
      int lat;
      job16(24'd5094007, 24'd0, 24'd4194304, 1'b0, lat);
      check16("k_job", 24'd5094007, 24'd0, 24'd4194304, 1'b0, lat);
`ifdef CORDIC_EARLY_EXIT_EN
      n_cmp++; if ({ox16, oy16, oa16, oi16} !== {24'd5094007, 24'd5094007, 24'd4194304, 5'd1}) begin n_bad++; $display("FAIL k_early got x=%0d y=%0d a=%0d i=%0d want 5094007 5094007 4194304 1", ox16, oy16, oa16, oi16); end
`else
      n_cmp++; if (ox16 < 5931642 - 512 || ox16 > 5931642 + 512 || oy16 < 5931642 - 512 || oy16 > 5931642 + 512) begin n_bad++; $display("FAIL k_near got x=%0d y=%0d want about 5931642", ox16, oy16); end
`endif
      take16();
   endtask

   task automatic test_random;
      int lat;
      logic [23:0] x, y, t; logic f;
      for (int i = 0; i < 8; i++) begin
         x = 24'($urandom_range(4194304, 0) - 2097152);
         y = 24'($urandom_range(4194304, 0) - 2097152);
         t = 24'($urandom_range(8388608, 1));
         f = 1'($urandom_range(3, 0) == 0);
         job16(x, y, t, f, lat);
         check16("rand", x, y, t, f, lat);
         take16();
      end
   endtask

   task automatic test_force2;
      int lat;
      @(negedge clk);
      dx = 24'd5094007; dy = 0; dt = 24'd100; df = 1; iv2 = 1;
      @(negedge clk);
      iv2 = 0; lat = 0; df = 0;
      while (!ov2 && lat < 50) begin @(negedge clk); lat++; end
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL force2_latency got %0d want 2", lat); end
      n_cmp++; if (oa2 !== 24'd6670347) begin n_bad++; $display("FAIL force2_angle got %0d want 6670347", oa2); end
      n_cmp++; if (ox2 !== 24'sd2547004 || oy2 !== 24'sd7641010) begin n_bad++; $display("FAIL force2_xy got %0d %0d want 2547004 7641010", ox2, oy2); end
      n_cmp++; if (oi2 !== 5'd2) begin n_bad++; $display("FAIL force2_iters got %0d want 2", oi2); end
      or2 = 1; @(negedge clk); or2 = 0;
   endtask

   task automatic test_iter1;
      int lat, ec;
      logic [23:0] ex, ey, ea;
      @(negedge clk);
      dx = 24'($urandom_range(4194304, 0) - 2097152); dy = 24'($urandom_range(4194304, 0) - 2097152);
      dt = 24'($urandom_range(8388608, 1)); df = 0; iv1 = 1;
      model(dx, dy, dt, 1'b0, 1, ex, ey, ea, ec);
      @(negedge clk);
      iv1 = 0; lat = 0;
      while (!ov1 && lat < 50) begin @(negedge clk); lat++; end
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL iter1_latency got %0d want 1", lat); end
      n_cmp++; if ({ox1, oy1, oa1, oi1} !== {ex, ey, ea, 5'd1}) begin n_bad++; $display("FAIL iter1_result got %0d %0d %0d %0d want %0d %0d %0d 1", ox1, oy1, oa1, oi1, $signed(ex), $signed(ey), ea); end
      or1 = 1; @(negedge clk); or1 = 0;
   endtask

   task automatic test_hold;
      int lat;
      logic [76:0] snap;
      job16(24'd1000000, -24'sd300000, 24'd3000000, 1'b0, lat);
      check16("hold_first", 24'd1000000, -24'sd300000, 24'd3000000, 1'b0, lat);
      snap = {ox16, oy16, oa16, oi16};
      dx = 24'd12345; dy = 24'd54321; dt = 24'd777; df = 0; iv16 = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_cmp++; if ({ox16, oy16, oa16, oi16} !== snap || ov16 !== 1'b1 || rdy16 !== 1'b0) begin n_bad++; $display("FAIL hold_stable cycle %0d got %h v=%b r=%b want %h v=1 r=0", i, {ox16, oy16, oa16, oi16}, ov16, rdy16, snap); end
      end
      iv16 = 0;
      take16();
      n_cmp++; if (rdy16 !== 1'b1 || ov16 !== 1'b0) begin n_bad++; $display("FAIL hold_release got r=%b v=%b want r=1 v=0", rdy16, ov16); end
      job16(24'd2000000, 24'd500000, 24'd6000000, 1'b0, lat);
      check16("hold_next", 24'd2000000, 24'd500000, 24'd6000000, 1'b0, lat);
      take16();
   endtask

   task automatic test_back_to_back;
      int acc[$];
      @(negedge clk);
      dx = 24'd800000; dy = 24'd100000; dt = 24'd2000000; df = 1; or16 = 1; iv16 = 1;
      for (int i = 0; i < 80; i++) begin
         if (rdy16) acc.push_back(cyc);
         @(negedge clk);
      end
      iv16 = 0; df = 0;
      repeat (20) @(negedge clk);
      or16 = 0;
      n_cmp++; if (acc.size() < 4) begin n_bad++; $display("FAIL b2b_count got %0d want >=4", acc.size()); end
      for (int i = 1; i < acc.size(); i++) begin
         n_cmp++; if (acc[i] - acc[i-1] !== 18) begin n_bad++; $display("FAIL b2b_spacing got %0d want 18", acc[i] - acc[i-1]); end
      end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      dx = 24'd3000000; dy = 24'd1000000; dt = 24'd5000000; df = 0; iv16 = 1;
      @(negedge clk);
      iv16 = 0;
      repeat (5) @(negedge clk);
      rst_n = 0; #1;
      n_cmp++; if (rdy16 !== 1'b1 || ov16 !== 1'b0 || {ox16, oy16, oa16, oi16} !== 77'd0) begin n_bad++; $display("FAIL reset_mid got r=%b v=%b x=%0d y=%0d a=%0d i=%0d want r=1 v=0 zeros", rdy16, ov16, ox16, oy16, oa16, oi16); end
      @(negedge clk); rst_n = 1;
      repeat (20) @(negedge clk);
      n_cmp++; if (ov16 !== 1'b0 || rdy16 !== 1'b1) begin n_bad++; $display("FAIL reset_mid_discard got v=%b r=%b want v=0 r=1", ov16, rdy16); end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      test_reset();
      test_known();
      test_random();
      test_force2();
      test_iter1();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
